// File: rtl/wave_capture_sched.sv
// wave_capture_sched: capture scheduler for the double-buffered 512x8 waveform RAM.
// Arms on a positive zero crossing (or a timeout auto-trigger), writes 256 samples into
// the half the display is not reading, then waits for a display-idle rising edge to
// hand the finished half to the display. Display scale (w/h) is also swapped only on
// display-idle rising edges so a frame never changes scale mid-draw.
module wave_capture_sched #(
   parameter int TIMEOUT    = 1024,
   parameter int NSAMP_BITS = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  new_sample,
   input  logic [15:0]           sample_in,
   input  logic                  display_idle,
   input  logic                  cfg_load,
   input  logic [3:0]            w_req,
   input  logic [3:0]            h_req,
   output logic                  write_enable,
   output logic [NSAMP_BITS:0]   write_address,
   output logic [7:0]            write_sample,
   output logic                  read_index,
   output logic [3:0]            w,
   output logic [3:0]            h,
   output logic [1:0]            state,
   output logic                  capture_done
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   // Timeout counter only needs to reach TIMEOUT-1.
   localparam int                    CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam bit                    TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0]      TO_LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
   localparam logic [NSAMP_BITS-1:0] IDX_LAST = {NSAMP_BITS{1'b1}};

   // A scale request is legal only when exactly one bit is set.
   function automatic logic is_onehot4(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   state_t                state_r;
   state_t                state_nxt_s;
   logic [15:0]           prev_sample_r;
   logic [NSAMP_BITS-1:0] idx_r;
   logic [NSAMP_BITS-1:0] idx_nxt_s;
   logic [NSAMP_BITS-1:0] wr_idx_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic                  idle_d_r;
   logic [3:0]            pend_w_r;
   logic [3:0]            pend_h_r;
   logic                  trig_s;
   logic                  timeout_hit_s;
   logic                  idle_rise_s;
   logic                  cfg_ok_s;
   logic                  we_s;
   logic                  done_s;
   logic                  rd_nxt_s;

   assign trig_s        = new_sample & prev_sample_r[15] & ~sample_in[15];
   assign timeout_hit_s = TO_EN && new_sample && (cnt_r == TO_LAST);
   assign idle_rise_s   = display_idle & ~idle_d_r;
   assign cfg_ok_s      = cfg_load & is_onehot4(w_req) & is_onehot4(h_req);
   assign state         = state_r;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= ST_ARMED;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic: arm -> capture 256 -> wait for a display-idle rising edge.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_ARMED: begin
            if (trig_s || timeout_hit_s) begin
               state_nxt_s = ST_ACTIVE;
            end else begin
               state_nxt_s = ST_ARMED;
            end
         end
         ST_ACTIVE: begin
            if (new_sample && (idx_r == IDX_LAST)) begin
               state_nxt_s = ST_WAIT;
            end else begin
               state_nxt_s = ST_ACTIVE;
            end
         end
         ST_WAIT: begin
            if (idle_rise_s) begin
               state_nxt_s = ST_ARMED;
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_ARMED;
         end
      endcase
   end

   // Per-state write request, sample index, timeout count and buffer flip.
   always_comb begin
      we_s      = 1'b0;
      done_s    = 1'b0;
      wr_idx_s  = idx_r;
      idx_nxt_s = idx_r;
      cnt_nxt_s = cnt_r;
      rd_nxt_s  = read_index;
      case (state_r)
         ST_ARMED: begin
            if (trig_s || timeout_hit_s) begin
               // The triggering sample itself becomes index 0.
               we_s      = 1'b1;
               wr_idx_s  = {NSAMP_BITS{1'b0}};
               idx_nxt_s = NSAMP_BITS'(1);
               cnt_nxt_s = {CNT_W{1'b0}};
            end else if (new_sample) begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         ST_ACTIVE: begin
            if (new_sample) begin
               we_s      = 1'b1;
               wr_idx_s  = idx_r;
               idx_nxt_s = idx_r + NSAMP_BITS'(1);
               done_s    = (idx_r == IDX_LAST);
            end else begin
               we_s      = 1'b0;
            end
         end
         ST_WAIT: begin
            if (idle_rise_s) begin
               rd_nxt_s  = ~read_index;
               cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
               rd_nxt_s  = read_index;
            end
         end
         default: begin
            idx_nxt_s = {NSAMP_BITS{1'b0}};
            cnt_nxt_s = {CNT_W{1'b0}};
         end
      endcase
   end

   // Registered RAM write port, capture pulse, read half and capture bookkeeping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         write_enable  <= 1'b0;
         write_address <= {(NSAMP_BITS+1){1'b0}};
         write_sample  <= 8'h00;
         capture_done  <= 1'b0;
         read_index    <= 1'b0;
         idx_r         <= {NSAMP_BITS{1'b0}};
         cnt_r         <= {CNT_W{1'b0}};
         prev_sample_r <= 16'h0000;
      end else begin
         write_enable  <= we_s;
         capture_done  <= done_s;
         read_index    <= rd_nxt_s;
         idx_r         <= idx_nxt_s;
         cnt_r         <= cnt_nxt_s;
         if (we_s) begin
            // Target the half the display is not reading; convert to offset binary.
            write_address <= {~read_index, wr_idx_s};
            write_sample  <= {~sample_in[15], sample_in[14:8]};
         end
         if (new_sample) begin
            prev_sample_r <= sample_in;
         end
      end
   end

   // Display-scale configuration: pending latch plus frame-boundary swap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_d_r <= 1'b0;
         pend_w_r <= 4'b0001;
         pend_h_r <= 4'b1000;
         w        <= 4'b0001;
         h        <= 4'b1000;
      end else begin
         idle_d_r <= display_idle;
         if (cfg_ok_s) begin
            pend_w_r <= w_req;
            pend_h_r <= h_req;
         end
         if (idle_rise_s) begin
            // A legal request arriving on the swap edge takes effect immediately.
            w <= cfg_ok_s ? w_req : pend_w_r;
            h <= cfg_ok_s ? h_req : pend_h_r;
         end
      end
   end

endmodule

// File: tb/tb_wave_capture_sched.sv
// Self-checking bench for wave_capture_sched (TIMEOUT=4): vector table for the
// trigger/config path, hand sequences for full capture, buffer flip, timeout and reset.
module tb_wave_capture_sched;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        new_sample;
   logic [15:0] sample_in;
   logic        display_idle;
   logic        cfg_load;
   logic [3:0]  w_req;
   logic [3:0]  h_req;
   logic        write_enable;
   logic [8:0]  write_address;
   logic [7:0]  write_sample;
   logic        read_index;
   logic [3:0]  w;
   logic [3:0]  h;
   logic [1:0]  state;
   logic        capture_done;

   int n_checks = 0;
   int n_fail   = 0;
   int done_cnt = 0;

   wave_capture_sched #(.TIMEOUT(4), .NSAMP_BITS(8)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .new_sample    (new_sample),
      .sample_in     (sample_in),
      .display_idle  (display_idle),
      .cfg_load      (cfg_load),
      .w_req         (w_req),
      .h_req         (h_req),
      .write_enable  (write_enable),
      .write_address (write_address),
      .write_sample  (write_sample),
      .read_index    (read_index),
      .w             (w),
      .h             (h),
      .state         (state),
      .capture_done  (capture_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        ns;
      logic [15:0] smp;
      logic        idle;
      logic        cfg;
      logic [3:0]  wr;
      logic [3:0]  hr;
      logic        e_we;
      logic [8:0]  e_addr;
      logic [7:0]  e_samp;
      logic        e_ri;
      logic [3:0]  e_w;
      logic [3:0]  e_h;
      logic [1:0]  e_st;
      logic        e_done;
   } vec_t;

   vec_t vt[8];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Apply inputs at the falling edge, then sample 1 time unit after the rising edge.
   task automatic drive(input logic ns, input logic [15:0] s, input logic idle,
                        input logic cfg, input logic [3:0] wr, input logic [3:0] hr);
      @(negedge clk);
      new_sample   = ns;
      sample_in    = s;
      display_idle = idle;
      cfg_load     = cfg;
      w_req        = wr;
      h_req        = hr;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, {14'd0, state}, 16'd0);
      chk({tag, "_ri"}, {15'd0, read_index}, 16'd0);
      chk({tag, "_we"}, {15'd0, write_enable}, 16'd0);
      chk({tag, "_addr"}, {7'd0, write_address}, 16'd0);
      chk({tag, "_samp"}, {8'd0, write_sample}, 16'd0);
      chk({tag, "_done"}, {15'd0, capture_done}, 16'd0);
      chk({tag, "_w"}, {12'd0, w}, 16'h0001);
      chk({tag, "_h"}, {12'd0, h}, 16'h0008);
   endtask

   initial begin
      //         ns    smp       idle  cfg   wr       hr       we    addr     samp   ri    w        h        st    done
      vt[0] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'b0100, 4'b0010, 1'b0, 9'h000, 8'h00, 1'b0, 4'b0001, 4'b1000, 2'd0, 1'b0};
      vt[1] = '{1'b1, 16'hFFFB, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 9'h000, 8'h00, 1'b0, 4'b0001, 4'b1000, 2'd0, 1'b0};
      vt[2] = '{1'b1, 16'h0003, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 9'h100, 8'h80, 1'b0, 4'b0001, 4'b1000, 2'd1, 1'b0};
      vt[3] = '{1'b1, 16'h1234, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 9'h101, 8'h92, 1'b0, 4'b0001, 4'b1000, 2'd1, 1'b0};
      vt[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 9'h000, 8'h00, 1'b0, 4'b0100, 4'b0010, 2'd1, 1'b0};
      vt[5] = '{1'b1, 16'h8000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b1, 9'h102, 8'h00, 1'b0, 4'b0100, 4'b0010, 2'd1, 1'b0};
      vt[6] = '{1'b1, 16'h7FFF, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b1, 9'h103, 8'hFF, 1'b0, 4'b0100, 4'b0010, 2'd1, 1'b0};
      vt[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 4'b0110, 4'b0001, 1'b0, 9'h000, 8'h00, 1'b0, 4'b0100, 4'b0010, 2'd1, 1'b0};

      reset_n      = 1'b0;
      new_sample   = 1'b0;
      sample_in    = 16'h0000;
      display_idle = 1'b0;
      cfg_load     = 1'b0;
      w_req        = 4'b0000;
      h_req        = 4'b0000;
      #22;
      chk_reset_vals("rst");
      @(negedge clk);
      reset_n = 1'b1;

      // Trigger, first writes, config latch and idle rise during capture.
      for (int i = 0; i < 8; i++) begin
         drive(vt[i].ns, vt[i].smp, vt[i].idle, vt[i].cfg, vt[i].wr, vt[i].hr);
         chk($sformatf("v%0d_we", i), {15'd0, write_enable}, {15'd0, vt[i].e_we});
         chk($sformatf("v%0d_state", i), {14'd0, state}, {14'd0, vt[i].e_st});
         chk($sformatf("v%0d_ri", i), {15'd0, read_index}, {15'd0, vt[i].e_ri});
         chk($sformatf("v%0d_w", i), {12'd0, w}, {12'd0, vt[i].e_w});
         chk($sformatf("v%0d_h", i), {12'd0, h}, {12'd0, vt[i].e_h});
         chk($sformatf("v%0d_done", i), {15'd0, capture_done}, {15'd0, vt[i].e_done});
         if (vt[i].e_we) begin
            chk($sformatf("v%0d_addr", i), {7'd0, write_address}, {7'd0, vt[i].e_addr});
            chk($sformatf("v%0d_samp", i), {8'd0, write_sample}, {8'd0, vt[i].e_samp});
         end
      end

      // Finish the capture back-to-back; display_idle rises at index 200 and stays high.
      for (int i = 4; i < 256; i++) begin
         drive(1'b1, 16'h0100, (i >= 200) ? 1'b1 : 1'b0, 1'b0, 4'b0000, 4'b0000);
         chk($sformatf("cap_we%0d", i), {15'd0, write_enable}, 16'd1);
         chk($sformatf("cap_addr%0d", i), {7'd0, write_address}, 16'h0100 + 16'(i));
         chk($sformatf("cap_done%0d", i), {15'd0, capture_done}, (i == 255) ? 16'd1 : 16'd0);
         if (capture_done) done_cnt++;
      end
      chk("cap_samp", {8'd0, write_sample}, 16'h0081);
      chk("done_pulses", done_cnt[15:0], 16'd1);
      chk("wait_state", {14'd0, state}, 16'd2);
      chk("bad_cfg_w", {12'd0, w}, 16'h0004);
      chk("bad_cfg_h", {12'd0, h}, 16'h0002);

      // WAIT with display_idle already high: no flip, strobes ignored.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0100, 1'b1, 1'b0, 4'b0000, 4'b0000);
         chk($sformatf("wait_we%0d", i), {15'd0, write_enable}, 16'd0);
         chk($sformatf("wait_ri%0d", i), {15'd0, read_index}, 16'd0);
         chk($sformatf("wait_st%0d", i), {14'd0, state}, 16'd2);
         chk($sformatf("wait_done%0d", i), {15'd0, capture_done}, 16'd0);
      end
      drive(1'b0, 16'h0100, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("idle_low_ri", {15'd0, read_index}, 16'd0);
      chk("idle_low_st", {14'd0, state}, 16'd2);
      drive(1'b0, 16'h0100, 1'b1, 1'b0, 4'b0000, 4'b0000);
      chk("flip_ri", {15'd0, read_index}, 16'd1);
      chk("flip_st", {14'd0, state}, 16'd0);

      // Timeout auto-trigger with constant positive input; capture into lower half.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 16'h0500, 1'b1, 1'b0, 4'b0000, 4'b0000);
         chk($sformatf("to_we%0d", i), {15'd0, write_enable}, 16'd0);
         chk($sformatf("to_st%0d", i), {14'd0, state}, 16'd0);
      end
      drive(1'b1, 16'h0500, 1'b1, 1'b0, 4'b0000, 4'b0000);
      chk("to_fire_we", {15'd0, write_enable}, 16'd1);
      chk("to_fire_addr", {7'd0, write_address}, 16'h0000);
      chk("to_fire_samp", {8'd0, write_sample}, 16'h0085);
      chk("to_fire_st", {14'd0, state}, 16'd1);
      for (int i = 1; i < 100; i++) begin
         drive(1'b1, 16'h0500, 1'b0, 1'b0, 4'b0000, 4'b0000);
         chk($sformatf("lo_we%0d", i), {15'd0, write_enable}, 16'd1);
         chk($sformatf("lo_addr%0d", i), {7'd0, write_address}, 16'(i));
      end

      // Asynchronous reset at idx=100, away from any clock edge.
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_vals("arst");
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 16'h0003, 1'b0, 1'b0, 4'b0000, 4'b0000);
         chk($sformatf("inrst_we%0d", i), {15'd0, write_enable}, 16'd0);
         chk($sformatf("inrst_st%0d", i), {14'd0, state}, 16'd0);
      end
      @(negedge clk);
      reset_n    = 1'b1;
      new_sample = 1'b0;

      // Restart after reset: new capture begins at index 0 in the upper half.
      drive(1'b1, 16'hFFFB, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("rs_neg_we", {15'd0, write_enable}, 16'd0);
      drive(1'b1, 16'h0003, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("rs_trig_we", {15'd0, write_enable}, 16'd1);
      chk("rs_trig_addr", {7'd0, write_address}, 16'h0100);
      chk("rs_trig_st", {14'd0, state}, 16'd1);
      drive(1'b1, 16'h0003, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("rs_next_addr", {7'd0, write_address}, 16'h0101);
      drive(1'b0, 16'h0000, 1'b0, 1'b0, 4'b0000, 4'b0000);
      chk("rs_idle_we", {15'd0, write_enable}, 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
